// File: rtl/pulse_sched.sv
// pulse_sched: shared pulse-timer scheduler.
// N requesters each ask for one timed pulse (dly cycles of wait, then len
// cycles high). A round-robin arbiter picks one job at a time, latches its
// timing, and drives a single shared counter and pulse output.
//
// Ports
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   req        level requests, held by requester i until done[i]
//   dly        per-requester delay, field i at [i*W +: W]
//   len        per-requester high time, field i at [i*W +: W]
//   pulse      shared pulse (registered)
//   pulse_sel  one-hot owner of pulse, zero while pulse is low
//   grant      index of current job owner, valid while busy
//   busy       high whenever a job or its trailing gap is in progress
//   done       one-cycle completion strobe for the owner
module pulse_sched #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned GAP = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       dly,
    input  logic [N*W-1:0]       len,
    output logic                 pulse,
    output logic [N-1:0]         pulse_sel,
    output logic [$clog2(N)-1:0] grant,
    output logic                 busy,
    output logic [N-1:0]         done
);

    localparam int unsigned GW = $clog2(N);

    // Reject unsupported parameterisations at elaboration.
    if (N < 2) begin : g_bad_n
        $error("pulse_sched: N must be at least 2");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("pulse_sched: GAP must be at least 1");
    end
    if (64'(GAP) > (64'(1) << W)) begin : g_big_gap
        $error("pulse_sched: GAP-1 must fit in the W-bit counter");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_HIGH  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   r_len;
    logic [GW-1:0]  r_last;
    logic [GW-1:0]  r_grant;
    logic           r_pulse;
    logic [N-1:0]   r_pulse_sel;
    logic           r_busy;
    logic [N-1:0]   r_done;

    logic [GW:0]    w_shift;
    logic [N-1:0]   w_rot;
    logic           w_found;
    logic [GW-1:0]  w_off;
    logic [GW:0]    w_sum;
    logic [GW-1:0]  w_win;
    logic [W-1:0]   w_win_dly;
    logic [W-1:0]   w_win_len;
    logic [N-1:0]   w_grant_oh;

    // Round-robin pick: rotate req so bit 0 is requester last+1, take the
    // lowest set bit, then map the offset back to an absolute index mod N.
    always_comb begin
        w_shift = (GW+1)'(r_last) + (GW+1)'(1);
        w_rot   = N'({req, req} >> w_shift);
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = GW'(i);
            end
        end
        w_sum = (GW+1)'(r_last) + (GW+1)'(1) + (GW+1)'(w_off);
        if (w_sum >= (GW+1)'(N)) begin
            w_sum = w_sum - (GW+1)'(N);
        end
        w_win     = GW'(w_sum);
        w_win_dly = '0;
        w_win_len = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == GW'(i)) begin
                w_win_dly = dly[i*W +: W];
                w_win_len = len[i*W +: W];
            end
        end
    end

    // One-hot decode of the current owner.
    always_comb begin
        w_grant_oh = '0;
        for (int i = 0; i < N; i++) begin
            w_grant_oh[i] = (r_grant == GW'(i));
        end
    end

    // Scheduler FSM with registered outputs; the counter only counts down
    // and every terminal action happens when it reads zero, so it never wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_last      <= GW'(N - 1);
            r_grant     <= '0;
            r_pulse     <= 1'b0;
            r_pulse_sel <= '0;
            r_busy      <= 1'b0;
            r_done      <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_DELAY;
                        r_grant <= w_win;
                        r_last  <= w_win;
                        r_cnt   <= w_win_dly;
                        r_len   <= w_win_len;
                        r_busy  <= 1'b1;
                    end
                end
                S_DELAY: begin
                    if (r_cnt == '0) begin
                        if (r_len != '0) begin
                            r_state     <= S_HIGH;
                            r_pulse     <= 1'b1;
                            r_pulse_sel <= w_grant_oh;
                            r_cnt       <= r_len - W'(1);
                        end else begin
                            r_state <= S_GAP;
                            r_done  <= w_grant_oh;
                            r_cnt   <= W'(GAP - 1);
                        end
                    end else begin
                        r_cnt <= r_cnt - W'(1);
                    end
                end
                S_HIGH: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_GAP;
                        r_pulse     <= 1'b0;
                        r_pulse_sel <= '0;
                        r_done      <= w_grant_oh;
                        r_cnt       <= W'(GAP - 1);
                    end else begin
                        r_cnt <= r_cnt - W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pulse     = r_pulse;
    assign pulse_sel = r_pulse_sel;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: randomized and directed stimulus for pulse_sched, checked
// every cycle against a job-level timing model (grant edge plus dly/len
// arithmetic), with literal timing expectations for the directed scenarios.
module tb_pulse_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int GAP = 1;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req;
    logic [N*W-1:0] dly;
    logic [N*W-1:0] len;
    logic           pulse;
    logic [N-1:0]   pulse_sel;
    logic [1:0]     grant;
    logic           busy;
    logic [N-1:0]   done;

    pulse_sched #(.N(N), .W(W), .GAP(GAP)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .dly       (dly),
        .len       (len),
        .pulse     (pulse),
        .pulse_sel (pulse_sel),
        .grant     (grant),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Job-level model state.
    bit m_job;
    int m_t0, m_d, m_l, m_owner, m_last, m_grant;
    int idx;
    bit found;
    int e_pulse, e_busy, e_done, e_sel;

    // Observations of the DUT used by the literal checks.
    bit p_busy, p_pulse;
    int g_edge, g_owner, rise_edge, done_edge, fall_edge;
    int pulse_cnt, done_val, done_cnt, sel_seen;
    int grant_log[$];
    int grant_edges[$];
    int s0, dc0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, exp);
        end
    endtask

    task automatic set_cfg(input int i, input int d, input int l);
        dly[i*W +: W] = W'(d);
        len[i*W +: W] = W'(l);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int s;
        s = grant_log.size();
        for (int k = 0; k < budget && grant_log.size() < s + n; k++) @(negedge clk);
        chk("grant_wait", grant_log.size() - s, n);
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy !== 1'b0; k++) @(negedge clk);
        chk("idle_wait", int'(busy), 0);
    endtask

    // Model update at each edge, then compare #1 later and log observations.
    initial begin
        m_job = 0; m_last = N - 1; m_grant = 0;
        m_t0 = 0; m_d = 0; m_l = 0; m_owner = 0;
        p_busy = 0; p_pulse = 0; done_cnt = 0; pulse_cnt = 0;
        g_edge = 0; g_owner = 0; rise_edge = 0; done_edge = 0; fall_edge = 0;
        done_val = 0; sel_seen = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn) begin
                m_job = 0; m_last = N - 1; m_grant = 0;
            end else if (!m_job || cyc >= m_t0 + m_d + m_l + GAP + 2) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!found && req[idx]) begin
                        found = 1;
                        m_owner = idx;
                    end
                end
                if (found) begin
                    m_job = 1; m_t0 = cyc;
                    m_d = int'(dly[m_owner*W +: W]);
                    m_l = int'(len[m_owner*W +: W]);
                    m_last = m_owner; m_grant = m_owner;
                end
            end
            #1;
            e_pulse = (m_job && cyc >= m_t0 + m_d + 1 && cyc < m_t0 + m_d + 1 + m_l) ? 1 : 0;
            e_busy  = (m_job && cyc < m_t0 + m_d + 1 + m_l + GAP) ? 1 : 0;
            e_done  = (m_job && cyc == m_t0 + m_d + 1 + m_l) ? (1 << m_owner) : 0;
            e_sel   = e_pulse ? (1 << m_owner) : 0;
            chk("pulse", int'(pulse), e_pulse);
            chk("busy", int'(busy), e_busy);
            chk("done", int'(done), e_done);
            chk("pulse_sel", int'(pulse_sel), e_sel);
            chk("grant", int'(grant), m_grant);

            if (busy && !p_busy) begin
                g_edge = cyc; g_owner = int'(grant); pulse_cnt = 0;
                grant_log.push_back(int'(grant));
                grant_edges.push_back(cyc);
            end
            if (pulse && !p_pulse) rise_edge = cyc;
            if (pulse) begin
                pulse_cnt++;
                sel_seen = int'(pulse_sel);
            end
            if (done != '0) begin
                done_edge = cyc; done_val = int'(done); done_cnt++;
            end
            if (!busy && p_busy) fall_edge = cyc;
            p_busy  = busy;
            p_pulse = pulse;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        req  = '1;
        dly  = '0;
        len  = '0;
        for (int i = 0; i < N; i++) set_cfg(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));

        // Reset held with all requests high: nothing may be granted.
        repeat (4) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulse", int'(pulse), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_no_grant", grant_log.size(), 0);
        req  = '0;
        rstn = 1'b1;
        @(negedge clk);

        // Single job: requester 0, dly=3, len=2.
        set_cfg(0, 3, 2);
        req = 4'b0001;
        wait_grants(1, 10);
        req = '0;
        wait_idle(20);
        chk("single_owner", g_owner, 0);
        chk("single_rise", rise_edge - g_edge, 4);
        chk("single_len", pulse_cnt, 2);
        chk("single_sel", sel_seen, 1);
        chk("single_done_t", done_edge - g_edge, 6);
        chk("single_done_v", done_val, 1);
        chk("single_busy_fall", fall_edge - g_edge, 7);

        // Zero timing on requester 2, then len=1.
        set_cfg(2, 0, 0);
        req = 4'b0100;
        wait_grants(1, 10);
        req = '0;
        wait_idle(20);
        chk("zero_owner", g_owner, 2);
        chk("zero_nopulse", pulse_cnt, 0);
        chk("zero_done_t", done_edge - g_edge, 1);
        chk("zero_done_v", done_val, 4);
        chk("zero_busy_fall", fall_edge - g_edge, 2);
        set_cfg(2, 0, 1);
        req = 4'b0100;
        wait_grants(1, 10);
        req = '0;
        wait_idle(20);
        chk("len1_rise", rise_edge - g_edge, 1);
        chk("len1_len", pulse_cnt, 1);
        chk("len1_done_t", done_edge - g_edge, 2);

        // Round-robin from a fresh reset with all requests held.
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < N; i++) set_cfg(i, 1, 1);
        s0 = grant_log.size();
        req = 4'b1111;
        wait_grants(5, 40);
        req = '0;
        wait_idle(20);
        if (grant_log.size() >= s0 + 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", grant_log[s0 + k], k % N);
            for (int k = 1; k < 5; k++) chk("rr_spacing", grant_edges[s0 + k] - grant_edges[s0 + k - 1], 5);
        end
        chk("rr_done_t", done_edge - g_edge, 3);

        // Reset in the middle of a pulse.
        set_cfg(0, 2, 10);
        req = 4'b0001;
        wait_grants(1, 10);
        for (int k = 0; k < 20 && cyc < g_edge + 5; k++) @(negedge clk);
        chk("mid_pre_pulse", int'(pulse), 1);
        dc0  = done_cnt;
        rstn = 1'b0;
        #1;
        chk("mid_async_pulse", int'(pulse), 0);
        chk("mid_async_busy", int'(busy), 0);
        chk("mid_async_sel", int'(pulse_sel), 0);
        repeat (3) @(negedge clk);
        chk("mid_no_done", done_cnt - dc0, 0);
        s0   = grant_log.size();
        req  = 4'b0110;
        rstn = 1'b1;
        wait_grants(2, 60);
        req = '0;
        wait_idle(60);
        if (grant_log.size() >= s0 + 2) begin
            chk("mid_first", grant_log[s0], 1);
            chk("mid_second", grant_log[s0 + 1], 2);
        end
        chk("mid_done_cnt", done_cnt - dc0, 2);

        // Maximum timing; configuration changes after grant must not matter.
        set_cfg(0, 255, 255);
        req = 4'b0001;
        wait_grants(1, 10);
        req = '0;
        for (int k = 0; k < 20 && cyc < g_edge + 10; k++) @(negedge clk);
        for (int i = 0; i < N; i++) set_cfg(i, 0, 0);
        wait_idle(600);
        chk("max_owner", g_owner, 0);
        chk("max_rise", rise_edge - g_edge, 256);
        chk("max_len", pulse_cnt, 255);
        chk("max_done_t", done_edge - g_edge, 511);
        chk("max_busy_fall", fall_edge - g_edge, 512);

        // Randomized traffic, occasional resets, shifting configuration.
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            rstn = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 2) == 0)
                set_cfg(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 5)),
                        int'($urandom_range(0, 4)));
        end
        @(negedge clk);
        rstn = 1'b1;
        req  = '0;
        wait_idle(100);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
